// File: rtl/mcp4725_i2c_target.sv
// Write-only I2C responder for the MCP4725 DAC protocol: matches the device address,
// ACKs bytes, decodes Fast Mode and Write-DAC-Register words and strobes each 12-bit code out.
module mcp4725_i2c_target #(
  parameter logic [5:0] ADDR_HI     = 6'b110000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        SCL_i,
  input  logic        SDA_i,
  input  logic        A0,
  output logic        SDA_t,
  output logic [11:0] data_reg,
  output logic [1:0]  mode_reg,
  output logic        update,
  output logic        busy,
  output logic [7:0]  nack_count
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK, RX, IGNORE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, sda_dly_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   full_q, full_d;
  logic [7:0]             shift_q, shift_d;
  logic [1:0]             idx_q, idx_d;
  logic                   fast_q, fast_d;
  logic [1:0]             pd_q, pd_d;
  logic [7:0]             dhi_q, dhi_d;
  logic                   sda_t_q, sda_t_d;
  logic [11:0]            data_q, data_d;
  logic [1:0]             mode_q, mode_d;
  logic                   update_q, update_d;
  logic                   busy_q, busy_d;
  logic [7:0]             nack_q, nack_d;

  logic scl, sda, scl_rise, scl_fall, start, stop;
  logic byte_done, addr_ok, addr_rd, cmd_fast, cmd_dac, cmd_bad, nack_inc;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL_i};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA_i};
  assign scl        = scl_sync_q[SYNC_STAGES-1];
  assign sda        = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl & ~scl_dly_q;
  assign scl_fall   = ~scl & scl_dly_q;
  assign start      = scl & scl_dly_q & sda_dly_q & ~sda;
  assign stop       = scl & scl_dly_q & ~sda_dly_q & sda;

  // A byte is decided on the SCL fall that follows its eighth rising edge.
  assign byte_done = scl_fall & full_q;
  assign addr_ok   = shift_q == {ADDR_HI, A0, 1'b0};
  assign addr_rd   = shift_q == {ADDR_HI, A0, 1'b1};
  assign cmd_fast  = shift_q[7:6] == 2'b00;
  assign cmd_dac   = shift_q[7:6] == 2'b01;
  assign cmd_bad   = (idx_q == 2'd0) & ~cmd_fast & ~cmd_dac;
  assign nack_inc  = byte_done & ((state_q == ADDR & addr_rd) | (state_q == RX & cmd_bad));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      bit_cnt_q  <= '0;
      full_q     <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      fast_q     <= 1'b0;
      pd_q       <= '0;
      dhi_q      <= '0;
      sda_t_q    <= 1'b1;
      data_q     <= '0;
      mode_q     <= '0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl;
      sda_dly_q  <= sda;
      bit_cnt_q  <= bit_cnt_d;
      full_q     <= full_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      fast_q     <= fast_d;
      pd_q       <= pd_d;
      dhi_q      <= dhi_d;
      sda_t_q    <= sda_t_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop)       state_d = IDLE;
    else if (start) state_d = ADDR;
    else begin
      case (state_q)
        ADDR:    if (byte_done) state_d = addr_ok ? ACK : IGNORE;
        ACK:     if (scl_fall)  state_d = RX;
        RX:      if (byte_done) state_d = cmd_bad ? IGNORE : ACK;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    full_d    = full_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    fast_d    = fast_q;
    pd_d      = pd_q;
    dhi_d     = dhi_q;
    sda_t_d   = sda_t_q;
    data_d    = data_q;
    mode_d    = mode_q;
    update_d  = 1'b0;
    busy_d    = busy_q;
    nack_d    = (nack_inc && nack_q != 8'hFF) ? nack_q + 8'd1 : nack_q;
    if (stop) begin
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      full_d    = 1'b0;
    end else if (start) begin
      sda_t_d   = 1'b1;
      bit_cnt_d = '0;
      full_d    = 1'b0;
      idx_d     = '0;
    end else begin
      if (scl_rise && (state_q == ADDR || state_q == RX)) begin
        shift_d   = {shift_q[6:0], sda};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) full_d = 1'b1;
      end
      case (state_q)
        ADDR: if (byte_done) begin
          full_d = 1'b0;
          busy_d = addr_ok;
          idx_d  = '0;
          if (addr_ok) sda_t_d = 1'b0;
        end
        ACK: if (scl_fall) sda_t_d = 1'b1;
        RX: if (byte_done) begin
          full_d = 1'b0;
          if (!cmd_bad) begin
            sda_t_d = 1'b0;
            case (idx_q)
              2'd0: begin
                fast_d = cmd_fast;
                pd_d   = cmd_fast ? shift_q[5:4] : shift_q[2:1];
                dhi_d  = {4'h0, shift_q[3:0]};
                idx_d  = 2'd1;
              end
              2'd1: begin
                if (fast_q) begin
                  data_d   = {dhi_q[3:0], shift_q};
                  mode_d   = pd_q;
                  update_d = 1'b1;
                  idx_d    = 2'd0;
                end else begin
                  dhi_d = shift_q;
                  idx_d = 2'd2;
                end
              end
              default: begin
                data_d   = {dhi_q, shift_q[7:4]};
                mode_d   = pd_q;
                update_d = 1'b1;
                idx_d    = 2'd0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA_t      = sda_t_q;
  assign data_reg   = data_q;
  assign mode_reg   = mode_q;
  assign update     = update_q;
  assign busy       = busy_q;
  assign nack_count = nack_q;

endmodule
